// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
// State encoding and the comparator flag sanity check live here.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } sar_state_e;

    function automatic logic onehot3(
        input logic eq,
        input logic lt,
        input logic gt
    );
        return ({eq, lt, gt} == 3'b100) ||
               ({eq, lt, gt} == 3'b010) ||
               ({eq, lt, gt} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// Bundle between the search engine and its comparator/controller side.
// master = search engine, slave = comparator plus whoever launches searches.
interface sar_search_if #(
    parameter int W = 4
);
    logic         start;
    logic         eq;
    logic         lt;
    logic         gt;
    logic [W-1:0] guess;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         found;
    logic         err;

    modport master (
        input  start, eq, lt, gt,
        output guess, busy, done, result, found, err
    );

    modport slave (
        output start, eq, lt, gt,
        input  guess, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search.sv
// Binary search for a hidden comparator target, MSB first, one probe per clock.
// Target 0 is never probed directly, so a VERIFY cycle confirms the final acc.
module sar_search
    import sar_pkg::*;
#(
    parameter int W = 4
) (
    input  logic      clk,
    input  logic      rst_b,
    sar_search_if.master bus
);
    localparam int IW = $clog2(W);

    sar_state_e   state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0] result_q, result_d;
    logic         found_q, found_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [W-1:0] trial;
    logic [W-1:0] guess;
    logic         flags_ok;

    assign trial    = acc_q | (W'(1) << idx_q);
    assign flags_ok = onehot3(bus.eq, bus.lt, bus.gt);

    always_comb begin
        guess = '0;
        unique case (state_q)
            PROBE:   guess = trial;
            VERIFY:  guess = acc_q;
            default: guess = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    idx_d   = IW'(W - 1);
                    err_d   = 1'b0;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                // Bad flags win over any decision made this cycle.
                if (!flags_ok) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = guess;
                    state_d  = DONE;
                end else if (bus.eq) begin
                    result_d = guess;
                    found_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    if (bus.lt) begin
                        acc_d = trial;
                    end
                    if (idx_q == '0) begin
                        state_d = VERIFY;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
            VERIFY: begin
                if (!flags_ok) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = guess;
                end else begin
                    result_d = acc_q;
                    found_d  = bus.eq;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == PROBE) || (state_d == VERIFY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= IW'(W - 1);
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.guess  = guess;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural comparator plus a binary-search reference
// model that predicts every output on every cycle of each search.
module tb_sar_search;
    localparam int W = 4;

    logic clk;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] target;
    logic         fault_en;
    logic [W-1:0] fault_g;
    logic         chk_en;

    sar_search_if #(.W(W)) bus ();

    sar_search #(.W(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        bus.eq = (bus.guess == target);
        bus.lt = (bus.guess < target);
        bus.gt = (bus.guess > target);
        if (fault_en && bus.guess == fault_g) begin
            bus.eq = 1'b0;
            bus.lt = 1'b1;
            bus.gt = 1'b1;
        end
    end

    typedef struct {
        logic [W-1:0] guess;
        logic         busy;
        logic         done;
        logic [W-1:0] result;
        logic         found;
        logic         err;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] m_result;
    logic         m_found;
    logic         m_err;

    function automatic exp_t mk(input int g, input bit b, input bit d,
                                input int r, input bit f, input bit e);
        exp_t x;
        x.guess  = W'(g);
        x.busy   = b;
        x.done   = d;
        x.result = W'(r);
        x.found  = f;
        x.err    = e;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_b && chk_en) begin
            exp_t e;
            if (q.size() > 0) e = q.pop_front();
            else e = mk(0, 0, 0, int'(m_result), m_found, m_err);
            check("guess",  32'(bus.guess),  32'(e.guess));
            check("busy",   32'(bus.busy),   32'(e.busy));
            check("done",   32'(bus.done),   32'(e.done));
            check("result", 32'(bus.result), 32'(e.result));
            check("found",  32'(bus.found),  32'(e.found));
            check("err",    32'(bus.err),    32'(e.err));
        end
    end

    // Predict a whole search: interval halving over [lo, lo+span).
    task automatic plan(input int tgt, input int fault);
        int lo;
        int span;
        int g;
        int res;
        bit fin;
        bit fnd;
        bit er;
        lo   = 0;
        span = 1 << W;
        fin  = 0;
        res  = 0;
        fnd  = 0;
        er   = 0;
        q.push_back(mk(0, 0, 0, int'(m_result), m_found, m_err));
        for (int k = 0; k < W && !fin; k++) begin
            span = span / 2;
            g = lo + span;
            q.push_back(mk(g, 1, 0, int'(m_result), m_found, 0));
            if (g == fault) begin
                fin = 1; res = g; fnd = 0; er = 1;
            end else if (g == tgt) begin
                fin = 1; res = g; fnd = 1; er = 0;
            end else if (g < tgt) begin
                lo = g;
            end
        end
        if (!fin) begin
            q.push_back(mk(lo, 1, 0, int'(m_result), m_found, 0));
            if (lo == fault) begin
                res = lo; fnd = 0; er = 1;
            end else begin
                res = lo; fnd = (lo == tgt); er = 0;
            end
        end
        q.push_back(mk(0, 0, 1, res, fnd, er));
        m_result = W'(res);
        m_found  = fnd;
        m_err    = er;
    endtask

    task automatic run(input int tgt, input int fault, input int mid_start,
                       input int rst_at, output int done_c,
                       output logic [31:0] seq, output int busy_n);
        done_c = 0;
        seq    = '0;
        busy_n = 0;
        target   = W'(tgt);
        fault_en = (fault >= 0);
        fault_g  = W'(fault);
        plan(tgt, fault);
        bus.start = 1'b1;
        for (int c = 1; c <= W + 4; c++) begin
            @(posedge clk);
            #2;
            bus.start = (c == mid_start);
            if (c == rst_at) begin
                rst_b = 1'b0;
                q.delete();
                m_result = '0;
                m_found  = 1'b0;
                m_err    = 1'b0;
                #1;
                check("rst_guess",  32'(bus.guess),  0);
                check("rst_busy",   32'(bus.busy),   0);
                check("rst_done",   32'(bus.done),   0);
                check("rst_result", 32'(bus.result), 0);
                check("rst_found",  32'(bus.found),  0);
                check("rst_err",    32'(bus.err),    0);
                repeat (2) @(posedge clk);
                #2;
                rst_b = 1'b1;
                break;
            end
            if (bus.busy) begin
                busy_n++;
                seq = (seq << W) | 32'(bus.guess);
            end
            if (bus.done && done_c == 0) done_c = c;
        end
        bus.start = 1'b0;
        fault_en  = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int          dc;
        logic [31:0] sq;
        int          bn;
        rst_b     = 1'b0;
        chk_en    = 1'b0;
        bus.start = 1'b0;
        target    = '0;
        fault_en  = 1'b0;
        fault_g   = '0;
        m_result  = '0;
        m_found   = 1'b0;
        m_err     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("init_guess",  32'(bus.guess),  0);
        check("init_busy",   32'(bus.busy),   0);
        check("init_done",   32'(bus.done),   0);
        check("init_result", 32'(bus.result), 0);
        check("init_found",  32'(bus.found),  0);
        check("init_err",    32'(bus.err),    0);
        rst_b  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #2;

        run(8, -1, -1, -1, dc, sq, bn);
        check("t8_lat",    32'(dc), 2);
        check("t8_result", 32'(bus.result), 8);
        check("t8_found",  32'(bus.found),  1);

        run(11, -1, 2, -1, dc, sq, bn);
        check("t11_lat", 32'(dc), 5);
        check("t11_seq", sq, 32'h8CAB);

        run(0, -1, -1, -1, dc, sq, bn);
        check("t0_lat",   32'(dc), 6);
        check("t0_seq",   sq, 32'h84210);
        check("t0_found", 32'(bus.found), 1);

        run(15, -1, -1, -1, dc, sq, bn);
        check("t15_busy", 32'(bn), 4);
        check("t15_seq",  sq, 32'h8CEF);

        run(11, 12, -1, -1, dc, sq, bn);
        check("flt_lat",   32'(dc), 3);
        check("flt_err",   32'(bus.err), 1);
        check("flt_found", 32'(bus.found), 0);

        run(5, -1, -1, -1, dc, sq, bn);
        check("clr_err",    32'(bus.err), 0);
        check("clr_result", 32'(bus.result), 5);

        run(11, -1, -1, 3, dc, sq, bn);
        run(11, -1, -1, -1, dc, sq, bn);
        check("post_rst_result", 32'(bus.result), 11);
        check("post_rst_lat",    32'(dc), 5);

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
